// File: rtl/storage_alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// storage_alu_sequencer_if
//   Bundles the start request and the memory / register-file / ALU control and
//   status signals that pass between the storage_alu_sequencer and its datapath.
//
//   master : sequencer view. It receives the start request, memory read data
//            and ALU result. It drives every strobe and the status outputs.
//   slave  : datapath / environment view, which is the mirror of master.
//
//   Signals
//     Start, Op, Addr_A, Addr_B, Addr_D        request (latched on Start)
//     Mem_Addr, Mem_Write, Mem_Din, Mem_Dout   data memory port
//     Reg_Write, Reg_W_Addr, Reg_W_Data        register-file write port
//     Reg_R_Addr_A, Reg_R_Addr_B               register-file read indices
//     ALU_OP, ALU_F, ALU_ZF                    ALU control and result
//     Busy, Done, Result, Zero                 status
// -----------------------------------------------------------------------------
interface storage_alu_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              Start;
  logic [2:0]        Op;
  logic [ADDR_W-1:0] Addr_A;
  logic [ADDR_W-1:0] Addr_B;
  logic [ADDR_W-1:0] Addr_D;

  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Write;
  logic [DATA_W-1:0] Mem_Din;
  logic [DATA_W-1:0] Mem_Dout;

  logic              Reg_Write;
  logic [4:0]        Reg_W_Addr;
  logic [DATA_W-1:0] Reg_W_Data;
  logic [4:0]        Reg_R_Addr_A;
  logic [4:0]        Reg_R_Addr_B;

  logic [2:0]        ALU_OP;
  logic [DATA_W-1:0] ALU_F;
  logic              ALU_ZF;

  logic              Busy;
  logic              Done;
  logic [DATA_W-1:0] Result;
  logic              Zero;

  modport master (
    input  Start, Op, Addr_A, Addr_B, Addr_D,
    input  Mem_Dout, ALU_F, ALU_ZF,
    output Mem_Addr, Mem_Write, Mem_Din,
    output Reg_Write, Reg_W_Addr, Reg_W_Data, Reg_R_Addr_A, Reg_R_Addr_B,
    output ALU_OP, Busy, Done, Result, Zero
  );

  modport slave (
    output Start, Op, Addr_A, Addr_B, Addr_D,
    output Mem_Dout, ALU_F, ALU_ZF,
    input  Mem_Addr, Mem_Write, Mem_Din,
    input  Reg_Write, Reg_W_Addr, Reg_W_Data, Reg_R_Addr_A, Reg_R_Addr_B,
    input  ALU_OP, Busy, Done, Result, Zero
  );
endinterface

// File: rtl/storage_alu_sequencer.sv
// -----------------------------------------------------------------------------
// storage_alu_sequencer
//   Controller for the storage/register/ALU datapath. On Start it reads two
//   memory words, loads them into register-file entries REG_A and REG_B, runs
//   one ALU operation on them and writes the result back to memory at Addr_D.
//   The datapath is passive, so this block issues every strobe.
//
//   Ports
//     Storage_clk_m    system clock, rising edge
//     Storage_Reset_n  asynchronous active-low reset
//     bus              storage_alu_sequencer_if.master (request, memory,
//                      register-file, ALU and status signals)
//
//   Sequence (one state per cycle)
//     IDLE -> RD_A -> WAIT_A -> LD_A -> RD_B -> WAIT_B -> LD_B -> EXEC -> WB
//     -> DONE -> IDLE
// -----------------------------------------------------------------------------
module storage_alu_sequencer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_A  = 1,
  parameter int unsigned REG_B  = 2
) (
  input logic                     Storage_clk_m,
  input logic                     Storage_Reset_n,
  storage_alu_sequencer_if.master bus
);

  localparam logic [4:0] REG_A_IDX = 5'(REG_A);
  localparam logic [4:0] REG_B_IDX = 5'(REG_B);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_A,
    S_WAIT_A,
    S_LD_A,
    S_RD_B,
    S_WAIT_B,
    S_LD_B,
    S_EXEC,
    S_WB,
    S_DONE
  } state_e;

  state_e            state_q,      state_d;
  logic [2:0]        op_q,         op_d;
  logic [ADDR_W-1:0] addr_a_q,     addr_a_d;
  logic [ADDR_W-1:0] addr_b_q,     addr_b_d;
  logic [ADDR_W-1:0] addr_d_q,     addr_d_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic              mem_write_q,  mem_write_d;
  logic [DATA_W-1:0] mem_din_q,    mem_din_d;
  logic              reg_write_q,  reg_write_d;
  logic [4:0]        reg_w_addr_q, reg_w_addr_d;
  logic [DATA_W-1:0] reg_w_data_q, reg_w_data_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;
  logic [DATA_W-1:0] result_q,     result_d;
  logic              zero_q,       zero_d;

  // Outputs are registered: each transition computes the values that belong
  // to the state being entered, so every strobe lines up with its state.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    addr_d_d     = addr_d_q;
    result_d     = result_q;
    zero_d       = zero_q;
    mem_addr_d   = '0;
    mem_write_d  = 1'b0;
    mem_din_d    = '0;
    reg_write_d  = 1'b0;
    reg_w_addr_d = '0;
    reg_w_data_d = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          op_d       = bus.Op;
          addr_a_d   = bus.Addr_A;
          addr_b_d   = bus.Addr_B;
          addr_d_d   = bus.Addr_D;
          // Latched copy is not visible yet, so take the address straight
          // from the request.
          mem_addr_d = bus.Addr_A;
          busy_d     = 1'b1;
          state_d    = S_RD_A;
        end
      end
      S_RD_A: begin
        mem_addr_d = addr_a_q;
        busy_d     = 1'b1;
        state_d    = S_WAIT_A;
      end
      S_WAIT_A: begin
        // Read data is valid at the end of WAIT_A; capture it for LD_A.
        reg_write_d  = 1'b1;
        reg_w_addr_d = REG_A_IDX;
        reg_w_data_d = bus.Mem_Dout;
        busy_d       = 1'b1;
        state_d      = S_LD_A;
      end
      S_LD_A: begin
        mem_addr_d = addr_b_q;
        busy_d     = 1'b1;
        state_d    = S_RD_B;
      end
      S_RD_B: begin
        mem_addr_d = addr_b_q;
        busy_d     = 1'b1;
        state_d    = S_WAIT_B;
      end
      S_WAIT_B: begin
        reg_write_d  = 1'b1;
        reg_w_addr_d = REG_B_IDX;
        reg_w_data_d = bus.Mem_Dout;
        busy_d       = 1'b1;
        state_d      = S_LD_B;
      end
      S_LD_B: begin
        busy_d  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Result and the write-back data are the same ALU sample.
        result_d    = bus.ALU_F;
        zero_d      = bus.ALU_ZF;
        mem_addr_d  = addr_d_q;
        mem_din_d   = bus.ALU_F;
        mem_write_d = 1'b1;
        busy_d      = 1'b1;
        state_d     = S_WB;
      end
      S_WB: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Storage_clk_m or negedge Storage_Reset_n) begin
    if (!Storage_Reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      addr_d_q     <= '0;
      mem_addr_q   <= '0;
      mem_write_q  <= 1'b0;
      mem_din_q    <= '0;
      reg_write_q  <= 1'b0;
      reg_w_addr_q <= '0;
      reg_w_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      addr_d_q     <= addr_d_d;
      mem_addr_q   <= mem_addr_d;
      mem_write_q  <= mem_write_d;
      mem_din_q    <= mem_din_d;
      reg_write_q  <= reg_write_d;
      reg_w_addr_q <= reg_w_addr_d;
      reg_w_data_q <= reg_w_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

  assign bus.Mem_Addr     = mem_addr_q;
  assign bus.Mem_Write    = mem_write_q;
  assign bus.Mem_Din      = mem_din_q;
  assign bus.Reg_Write    = reg_write_q;
  assign bus.Reg_W_Addr   = reg_w_addr_q;
  assign bus.Reg_W_Data   = reg_w_data_q;
  assign bus.Reg_R_Addr_A = REG_A_IDX;
  assign bus.Reg_R_Addr_B = REG_B_IDX;
  assign bus.ALU_OP       = op_q;
  assign bus.Busy         = busy_q;
  assign bus.Done         = done_q;
  assign bus.Result       = result_q;
  assign bus.Zero         = zero_q;

endmodule

// File: tb/tb_storage_alu_sequencer.sv
module tb_storage_alu_sequencer;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  storage_alu_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  storage_alu_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .REG_A(1), .REG_B(2)
  ) dut (
    .Storage_clk_m  (clk),
    .Storage_Reset_n(rst_n),
    .bus            (bus)
  );

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] rf      [32];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Datapath ALU behaviour (the environment this controller drives).
  function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return (a < b) ? 32'd1 : 32'd0;
      default: return a ^ b;
    endcase
  endfunction

  // Passive datapath: synchronous memory, register file, combinational ALU.
  always @(posedge clk) begin
    if (bus.Mem_Write) mem[bus.Mem_Addr] <= bus.Mem_Din;
    bus.Mem_Dout <= mem[bus.Mem_Addr];
  end

  always @(posedge clk) begin
    if (bus.Reg_Write) rf[bus.Reg_W_Addr] <= bus.Reg_W_Data;
  end

  always_comb begin
    bus.ALU_F  = alu_f(bus.ALU_OP, rf[bus.Reg_R_Addr_A], rf[bus.Reg_R_Addr_B]);
    bus.ALU_ZF = (bus.ALU_F == '0);
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  // One full transaction. Start is driven in the IDLE cycle (cycle 1); the
  // loop observes cycles 2..10 mid-cycle. With noisy set, Start stays high and
  // the request inputs are scrambled on every later cycle.
  task automatic run_seq(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input bit noisy);
    logic [DW-1:0] va, vb, vr;
    int wr_cnt;
    va = ref_mem[a];
    vb = ref_mem[b];
    vr = alu_f(op, va, vb);
    wr_cnt = 0;
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Op     = op;
    bus.Addr_A = a;
    bus.Addr_B = b;
    bus.Addr_D = d;
    for (int cyc = 2; cyc <= 10; cyc++) begin
      @(negedge clk);
      check("busy", 64'(bus.Busy), 64'(cyc <= 9));
      check("done", 64'(bus.Done), 64'(cyc == 10));
      check("reg_write", 64'(bus.Reg_Write), 64'(cyc == 4 || cyc == 7));
      check("mem_write", 64'(bus.Mem_Write), 64'(cyc == 9));
      if (bus.Reg_Write) begin
        check("reg_w_addr", 64'(bus.Reg_W_Addr), (cyc == 4) ? 64'd1 : 64'd2);
        check("reg_w_data", 64'(bus.Reg_W_Data), (cyc == 4) ? 64'(va) : 64'(vb));
      end
      if (bus.Mem_Write) begin
        wr_cnt++;
        check("wb_addr", 64'(bus.Mem_Addr), 64'(d));
        check("wb_din", 64'(bus.Mem_Din), 64'(vr));
      end
      if (cyc == 2 || cyc == 3) check("mem_addr_a", 64'(bus.Mem_Addr), 64'(a));
      if (cyc == 5 || cyc == 6) check("mem_addr_b", 64'(bus.Mem_Addr), 64'(b));
      if (cyc == 8) check("alu_op", 64'(bus.ALU_OP), 64'(op));
      if (cyc == 10) begin
        check("mem_addr_done", 64'(bus.Mem_Addr), 64'd0);
        check("result", 64'(bus.Result), 64'(vr));
        check("zero", 64'(bus.Zero), 64'(vr == '0));
        check("mem_d", 64'(mem[d]), 64'(vr));
        check("wr_count", 64'(wr_cnt), 64'd1);
      end
      if (noisy) begin
        bus.Start  = 1'b1;
        bus.Op     = 3'($urandom);
        bus.Addr_A = AW'($urandom);
        bus.Addr_B = AW'($urandom);
        bus.Addr_D = AW'($urandom);
      end else begin
        bus.Start = 1'b0;
      end
    end
    ref_mem[d] = vr;
  endtask

  // After a noisy run: the Start seen in DONE must not launch a new sequence.
  task automatic idle_check();
    @(negedge clk);
    check("idle_busy", 64'(bus.Busy), 64'd0);
    check("idle_mem_addr", 64'(bus.Mem_Addr), 64'd0);
    bus.Start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_busy2", 64'(bus.Busy), 64'd0);
      check("idle_done2", 64'(bus.Done), 64'd0);
    end
  endtask

  task automatic reset_in_exec(input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic [AW-1:0] d);
    logic [DW-1:0] old;
    old = ref_mem[d];
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Op     = 3'b010;
    bus.Addr_A = a;
    bus.Addr_B = b;
    bus.Addr_D = d;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (6) @(negedge clk);  // now mid-EXEC (cycle 8)
    check("exec_busy_pre", 64'(bus.Busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_mem_write", 64'(bus.Mem_Write), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_mem_write", 64'(bus.Mem_Write), 64'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_mem_write", 64'(bus.Mem_Write), 64'd0);
      check("post_rst_busy", 64'(bus.Busy), 64'd0);
    end
    check("rst_mem_d_kept", 64'(mem[d]), 64'(old));
    check("rst_result", 64'(bus.Result), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] ra, rb, rd;
    bit nz;
    rst_n      = 1'b0;
    bus.Start  = 1'b1;
    bus.Op     = 3'b111;
    bus.Addr_A = 8'h11;
    bus.Addr_B = 8'h22;
    bus.Addr_D = 8'h33;
    for (int i = 0; i < 256; i++) poke(AW'(i), $urandom);
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Reset held with Start asserted: everything quiet.
    repeat (3) begin
      @(negedge clk);
      check("rst_mem_addr", 64'(bus.Mem_Addr), 64'd0);
      check("rst_mem_wr", 64'(bus.Mem_Write), 64'd0);
      check("rst_mem_din", 64'(bus.Mem_Din), 64'd0);
      check("rst_reg_wr", 64'(bus.Reg_Write), 64'd0);
      check("rst_alu_op", 64'(bus.ALU_OP), 64'd0);
      check("rst_busy0", 64'(bus.Busy), 64'd0);
      check("rst_done", 64'(bus.Done), 64'd0);
      check("rst_result0", 64'(bus.Result), 64'd0);
      check("rst_zero", 64'(bus.Zero), 64'd0);
    end
    check("rd_idx_a", 64'(bus.Reg_R_Addr_A), 64'd1);
    check("rd_idx_b", 64'(bus.Reg_R_Addr_B), 64'd2);
    bus.Start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("after_rst_busy", 64'(bus.Busy), 64'd0);

    // ADD
    poke(8'd3, 32'd5);
    poke(8'd4, 32'd7);
    run_seq(3'b010, 8'd3, 8'd4, 8'd5, 1'b0);
    check("add_mem5", 64'(mem[5]), 64'd12);

    // SUB to zero with aliasing, then rerun using the written-back value.
    poke(8'd1, 32'h8000_0000);
    poke(8'd2, 32'h8000_0000);
    run_seq(3'b110, 8'd1, 8'd2, 8'd1, 1'b0);
    check("sub_zero", 64'(bus.Zero), 64'd1);
    run_seq(3'b110, 8'd1, 8'd2, 8'd1, 1'b0);
    check("sub_wrap", 64'(mem[1]), 64'h8000_0000);

    // Start pulses throughout a run are ignored.
    run_seq(3'b001, 8'd10, 8'd11, 8'd12, 1'b1);
    idle_check();

    // Back-to-back: Start in the IDLE cycle right after Done.
    poke(8'd20, 32'h0000_F0F0);
    poke(8'd21, 32'h0000_0FF0);
    run_seq(3'b010, 8'd3, 8'd4, 8'd6, 1'b0);
    run_seq(3'b000, 8'd20, 8'd21, 8'd22, 1'b0);
    check("and_result", 64'(bus.Result), 64'h0000_00F0);

    // Reset during EXEC.
    reset_in_exec(8'd30, 8'd31, 8'd32);

    // Randomized runs over a small address window to exercise aliasing.
    for (int n = 0; n < 40; n++) begin
      ra = AW'($urandom_range(0, 7));
      rb = AW'($urandom_range(0, 7));
      rd = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) poke(rb, ref_mem[ra]);
      nz = ($urandom_range(0, 3) == 0);
      run_seq(3'($urandom), ra, rb, rd, nz);
      if (nz) idle_check();
    end
    for (int i = 0; i < 8; i++) check("final_mem", 64'(mem[i]), 64'(ref_mem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
